serial_addsub_unit: RTL and testbench
=====================================

Name: serial_addsub_unit

Overview:
- Parametrised bit-serial adder/subtractor. Accepts two WIDTH-bit operands in parallel, processes them LSB-first with one full-adder slice and a registered carry, then presents a parallel result with carry and signed-overflow flags.
- Successor to the single-bit serial adder: adds word width, a load/start/done handshake, subtract mode, and overflow detection.
- Sits between a register-file read port and a writeback stage in area-constrained datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only when busy=0
- sub  input  1  0 = A+B, 1 = A-B; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while the serial computation runs
- done  output  1  single-cycle pulse when result/cout/overflow are updated
- result  output  WIDTH  registered sum/difference
- cout  output  1  carry out of MSB (for subtraction: 1 = no borrow, a>=b unsigned)
- overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset (async assert, sync-release use): FSM=IDLE; busy=0, done=0, result=0, cout=0, overflow=0; internal shift registers, carry and counter cleared.
- FSM states: IDLE, RUN, FIN.
- IDLE: on edge with start=1, load shift_a<=a, shift_b<=(sub ? ~b : b), carry<=sub, bit counter<=0, go RUN. With start=0, stay.
- RUN: busy=1. Each edge computes s = shift_a[0]^shift_b[0]^carry and c = majority(shift_a[0], shift_b[0], carry).
  - Shift shift_a and shift_b right by 1.
  - Shift s into the MSB of the sum shift register.
  - carry<=c; counter++.
  - On the edge processing bit WIDTH-1, additionally record carry-into-MSB (the carry value before that edge) and go FIN.
  - start is ignored throughout RUN.
- FIN: entered with the full sum in the sum shift register. In this state:
  - done=1 and busy=0.
  - result, cout and overflow already hold the new values. They are registered on the RUN->FIN edge: result<=final sum, cout<=final carry, overflow<=carry_into_msb ^ final carry.
  - Next state is IDLE, unless start=1, in which case the new operands are loaded and the FSM goes straight to RUN (back-to-back operation with no idle cycle).
- Latency: start sampled at edge T0 -> busy=1 for cycles after T0 through T0+WIDTH -> done=1 for exactly the one cycle following edge T0+WIDTH.
- Throughput: one operation per WIDTH+1 cycles.
- result, cout and overflow hold their last values from one completion until the next completion; they do not change during RUN.
- Counter width is clog2(WIDTH)+1 bits. There is no wrap behaviour; the counter is reloaded on every start.
- Reset asserted mid-RUN aborts the operation immediately:
  - done is never pulsed for the aborted operation.
  - All outputs return to reset values.
- Operand inputs may change freely while busy=1 with no effect.
- sub applies only to the operation it was sampled with.

Test Plan:
- WIDTH=8, add 0x5A+0x3C -> after 9 cycles done=1 for 1 cycle; result=0x96, cout=0, overflow=1; busy high exactly 8 cycles.
- Add 0xFF+0x01 -> result=0x00, cout=1, overflow=0.
- Subtract 0x10-0x20 -> result=0xF0, cout=0 (borrow), overflow=0. Subtract 0x80-0x01 -> result=0x7F, cout=1, overflow=1.
- start pulsed with new operands during RUN (cycles 3 and 5) -> ignored. Result equals the first operation's value, and exactly one done pulse occurs.
- start held high in the FIN cycle with 0x01+0x02 after a 0x0F+0x01 operation:
  - done pulses with result=0x10.
  - busy rises on the next cycle with no IDLE gap.
  - 9 cycles later result=0x03.
- reset asserted asynchronously mid-clock at bit 4 of an operation -> all outputs 0 immediately with no done pulse. A subsequent 0x7F+0x01 yields result=0x80, overflow=1. Repeat the first three vectors with WIDTH=2 and WIDTH=32 (sign-extended equivalents).

Source files
------------

// File: rtl/serial_addsub_unit.sv
// Bit-serial add/subtract of two WIDTH-bit operands, LSB first, one full-adder slice.
// Latency WIDTH+1 cycles from start to the done pulse; start is ignored while busy, accepted in IDLE or FIN.
module serial_addsub_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-2:0] sum_sr;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;
    logic             load;
    logic             last;

    always_comb begin
        s_bit   = shift_a[0] ^ shift_b[0] ^ carry;
        c_bit   = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry) | (shift_b[0] & carry);
        sum_nxt = {s_bit, sum_sr};
        load    = start && (state == IDLE || state == FIN);
        last    = (state == RUN) && (cnt == LAST_BIT);
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_BIT)
                    state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_a  <= '0;
            shift_b  <= '0;
            sum_sr   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with one.
            shift_a <= a;
            shift_b <= sub ? ~b : b;
            carry   <= sub;
            cnt     <= '0;
        end else if (state == RUN) begin
            shift_a <= shift_a >> 1;
            shift_b <= shift_b >> 1;
            sum_sr  <= sum_nxt[WIDTH-1:1];
            carry   <= c_bit;
            cnt     <= cnt + 1'b1;
            if (last) begin
                // carry still holds the carry into the MSB on this edge.
                result   <= sum_nxt;
                cout     <= c_bit;
                overflow <= carry ^ c_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed bench for serial_addsub_unit at WIDTH 8, 2 and 32 with hand-computed results.
module tb_serial_addsub_unit;

    logic        clk;
    logic        reset;
    logic        sub_w;
    logic [63:0] a_w;
    logic [63:0] b_w;
    logic        start8, start2, start32;
    logic        busy8, done8, cout8, ovf8;
    logic        busy2, done2, cout2, ovf2;
    logic        busy32, done32, cout32, ovf32;
    logic [7:0]  res8;
    logic [1:0]  res2;
    logic [31:0] res32;

    int checks   = 0;
    int failures = 0;

    serial_addsub_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub_w),
        .a(a_w[7:0]), .b(b_w[7:0]), .busy(busy8), .done(done8),
        .result(res8), .cout(cout8), .overflow(ovf8)
    );

    serial_addsub_unit #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .sub(sub_w),
        .a(a_w[1:0]), .b(b_w[1:0]), .busy(busy2), .done(done2),
        .result(res2), .cout(cout2), .overflow(ovf2)
    );

    serial_addsub_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .sub(sub_w),
        .a(a_w[31:0]), .b(b_w[31:0]), .busy(busy32), .done(done32),
        .result(res32), .cout(cout32), .overflow(ovf32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic busy_of(input int w);
        case (w)
            2:       return busy2;
            32:      return busy32;
            default: return busy8;
        endcase
    endfunction

    function automatic logic done_of(input int w);
        case (w)
            2:       return done2;
            32:      return done32;
            default: return done8;
        endcase
    endfunction

    function automatic logic [63:0] res_of(input int w);
        case (w)
            2:       return {62'd0, res2};
            32:      return {32'd0, res32};
            default: return {56'd0, res8};
        endcase
    endfunction

    function automatic logic cout_of(input int w);
        case (w)
            2:       return cout2;
            32:      return cout32;
            default: return cout8;
        endcase
    endfunction

    function automatic logic ovf_of(input int w);
        case (w)
            2:       return ovf2;
            32:      return ovf32;
            default: return ovf8;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            2:       start2  = v;
            32:      start32 = v;
            default: start8  = v;
        endcase
    endtask

    // One full operation: latency, busy length, flags and single-cycle done.
    task automatic run_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                          input logic sb, input logic [63:0] er, input logic ec,
                          input logic eo, input string tag);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        a_w   = av;
        b_w   = bv;
        sub_w = sb;
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        set_start(w, 1'b0);
        a_w   = ~av;
        b_w   = ~bv;
        sub_w = ~sb;
        cycles   = 0;
        busy_cnt = 0;
        while (!done_of(w) && cycles < 200) begin
            if (busy_of(w))
                busy_cnt++;
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, " latency"}, 64'(cycles), 64'(w));
        check({tag, " busy_len"}, 64'(busy_cnt), 64'(w));
        check({tag, " busy_in_fin"}, {63'd0, busy_of(w)}, 64'd0);
        check({tag, " result"}, res_of(w), er);
        check({tag, " cout"}, {63'd0, cout_of(w)}, {63'd0, ec});
        check({tag, " overflow"}, {63'd0, ovf_of(w)}, {63'd0, eo});
        @(posedge clk);
        #1;
        check({tag, " done_single"}, {63'd0, done_of(w)}, 64'd0);
    endtask

    initial begin
        int dones;
        reset   = 1'b1;
        start8  = 1'b0;
        start2  = 1'b0;
        start32 = 1'b0;
        sub_w   = 1'b0;
        a_w     = '0;
        b_w     = '0;
        repeat (2) @(negedge clk);
        check("rst busy", {63'd0, busy8}, 64'd0);
        check("rst done", {63'd0, done8}, 64'd0);
        check("rst result", {56'd0, res8}, 64'd0);
        check("rst cout", {63'd0, cout8}, 64'd0);
        check("rst overflow", {63'd0, ovf8}, 64'd0);
        reset = 1'b0;

        run_op(8, 64'h5A, 64'h3C, 1'b0, 64'h96, 1'b0, 1'b1, "w8 5A+3C");
        run_op(8, 64'hFF, 64'h01, 1'b0, 64'h00, 1'b1, 1'b0, "w8 FF+01");
        run_op(8, 64'h10, 64'h20, 1'b1, 64'hF0, 1'b0, 1'b0, "w8 10-20");
        run_op(8, 64'h80, 64'h01, 1'b1, 64'h7F, 1'b1, 1'b1, "w8 80-01");

        // start pulses during RUN must be ignored
        @(negedge clk);
        a_w = 64'h12; b_w = 64'h34; sub_w = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dones  = 0;
        for (int i = 1; i < 14; i++) begin
            if (i == 3 || i == 5) begin
                a_w = 64'h77; b_w = 64'h11; sub_w = 1'b1; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            if (done8) begin
                dones++;
                check("ign result", {56'd0, res8}, 64'h46);
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        check("ign done_count", 64'(dones), 64'd1);
        repeat (12) @(negedge clk);

        // back-to-back: restart in the FIN cycle
        a_w = 64'h0F; b_w = 64'h01; sub_w = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        for (int i = 0; i < 200 && !done8; i++) begin
            @(posedge clk);
            #1;
        end
        check("b2b done1", {63'd0, done8}, 64'd1);
        check("b2b result1", {56'd0, res8}, 64'h10);
        a_w = 64'h01; b_w = 64'h02; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        check("b2b busy_rise", {63'd0, busy8}, 64'd1);
        check("b2b hold_result", {56'd0, res8}, 64'h10);
        repeat (8) @(posedge clk);
        #1;
        check("b2b done2", {63'd0, done8}, 64'd1);
        check("b2b result2", {56'd0, res8}, 64'h03);

        // asynchronous reset while bit 4 is in flight
        @(negedge clk);
        a_w = 64'hAA; b_w = 64'h55; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst busy", {63'd0, busy8}, 64'd0);
        check("arst done", {63'd0, done8}, 64'd0);
        check("arst result", {56'd0, res8}, 64'd0);
        check("arst cout", {63'd0, cout8}, 64'd0);
        check("arst overflow", {63'd0, ovf8}, 64'd0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 2)
                reset = 1'b0;
            if (done8)
                dones++;
        end
        check("arst no_done", 64'(dones), 64'd0);
        run_op(8, 64'h7F, 64'h01, 1'b0, 64'h80, 1'b0, 1'b1, "w8 7F+01");

        run_op(2, 64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b1, "w2 1+1");
        run_op(2, 64'h3, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, "w2 3+1");
        run_op(2, 64'h0, 64'h1, 1'b1, 64'h3, 1'b0, 1'b0, "w2 0-1");
        run_op(2, 64'h2, 64'h1, 1'b1, 64'h1, 1'b1, 1'b1, "w2 2-1");

        run_op(32, 64'h5A000000, 64'h3C000000, 1'b0, 64'h96000000, 1'b0, 1'b1, "w32 add_ovf");
        run_op(32, 64'hFFFFFFFF, 64'h00000001, 1'b0, 64'h00000000, 1'b1, 1'b0, "w32 wrap");
        run_op(32, 64'h00000010, 64'h00000020, 1'b1, 64'hFFFFFFF0, 1'b0, 1'b0, "w32 borrow");
        run_op(32, 64'h80000000, 64'h00000001, 1'b1, 64'h7FFFFFFF, 1'b1, 1'b1, "w32 sub_ovf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
